mul_div_unit: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the execute stage beside the ALU. It accepts one operation per start pulse, holds `busy` for the operation's latency, then commits results to HI/LO. The execute stage is the initiator of this handshake. Decode stalls HI/LO-dependent instructions while `start || busy`.

---
 rtl/mul_div_if.sv | 13 +
 rtl/mul_div_unit.sv | 123 ++++++++++++
 tb/tb_mul_div_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// Execute-stage handshake to the multiply/divide unit: request, operands, busy and HI/LO.
interface mul_div_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   reset,
    mul_div_if.slave bus
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pend_hi_q, pend_hi_d;
    logic [31:0]     pend_lo_q, pend_lo_d;
    logic            pend_ok_q, pend_ok_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    logic [63:0] sprod, uprod;
    logic        b_nz;
    logic [31:0] b_safe, abs_a, abs_b, uq_s, ur_s, squo, srem, uquo, urem;

    // Results are formed combinationally at start; the counter only paces the commit.
    always_comb begin
        sprod  = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
        uprod  = {32'd0, bus.a} * {32'd0, bus.b};
        b_nz   = (bus.b != '0);
        b_safe = b_nz ? bus.b : 32'd1;
        abs_a  = bus.a[31] ? (32'd0 - bus.a) : bus.a;
        abs_b  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
        uq_s   = abs_a / abs_b;
        ur_s   = abs_a % abs_b;
        // Magnitude divide then re-sign: 0x80000000 / -1 falls out as lo=0x80000000, hi=0.
        squo   = (bus.a[31] ^ b_safe[31]) ? (32'd0 - uq_s) : uq_s;
        srem   = bus.a[31] ? (32'd0 - ur_s) : ur_s;
        uquo   = bus.a / b_safe;
        urem   = bus.a % b_safe;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = (bus.op == OP_MULT) ? sprod : uprod;
                            pend_ok_d = 1'b1;
                            count_d   = CW'(MULT_CYCLES);
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = (bus.op == OP_DIV) ? srem : urem;
                            pend_lo_d = (bus.op == OP_DIV) ? squo : uquo;
                            pend_ok_d = b_nz;
                            count_d   = CW'(DIV_CYCLES);
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;
    localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                           DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6, RSVD = 3'd7;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] exp_hi, exp_lo;

    mul_div_if bus ();

    mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one op, computed with wide host arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        longint          sa, sb, q, r, p;
        longint unsigned up;
        logic [63:0]     w;
        lat = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MULT:  begin p = sa * sb; w = p; exp_hi = w[63:32]; exp_lo = w[31:0]; lat = MC; end
            MULTU: begin up = longint'(a) * longint'(b); w = up; exp_hi = w[63:32]; exp_lo = w[31:0]; lat = MC; end
            DIV: begin
                lat = DC;
                if (b != 0) begin
                    q = sa / sb; r = sa % sb;
                    w = q; exp_lo = w[31:0];
                    w = r; exp_hi = w[31:0];
                end
            end
            DIVU: begin
                lat = DC;
                if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
            end
            MTHI: exp_hi = a;
            MTLO: exp_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge with the unit idle; returns at the first negedge with busy low.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] old_hi, old_lo;
        int lat, n;
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(op, a, b, lat);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = NONE;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            check({tag, "_hold_hi"}, bus.hi, old_hi);
            check({tag, "_hold_lo"}, bus.lo, old_lo);
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(lat));
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        int n;
        logic [31:0] old_hi, ra, rb;
        logic [2:0]  rop;
        int lat;

        reset = 1'b1;
        bus.start = 1'b0; bus.op = NONE; bus.a = '0; bus.b = '0;
        exp_hi = '0; exp_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);

        run_op("mult_neg", MULT, 32'hFFFFFFFE, 32'd3);
        run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op("div_neg", DIV, 32'hFFFFFFF9, 32'd2);
        run_op("mthi", MTHI, 32'h11, 32'd0);
        run_op("mtlo", MTLO, 32'h22, 32'd0);
        run_op("divu_zero", DIVU, 32'd7, 32'd0);
        run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF);
        run_op("mtlo_b2b", MTLO, 32'd5, 32'd0);
        run_op("none", NONE, 32'hAAAA5555, 32'd1);
        run_op("rsvd", RSVD, 32'h5555AAAA, 32'd1);

        // Reset on the third busy cycle of a MULT aborts it without commit.
        bus.start = 1'b1; bus.op = MULT; bus.a = 32'h7FFFFFFF; bus.b = 32'h7FFFFFFF;
        @(negedge clk);
        bus.start = 1'b0; bus.op = NONE;
        check("abort_busy1", 32'(bus.busy), 32'd1);
        repeat (2) @(negedge clk);
        check("abort_busy3", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        repeat (8) begin
            @(negedge clk);
            check("abort_no_commit_hi", bus.hi, 32'd0);
            check("abort_no_commit_lo", bus.lo, 32'd0);
        end

        run_op("mthi_pre", MTHI, 32'h0BADF00D, 32'd0);
        // A start presented while busy must be ignored, MTHI included.
        old_hi = exp_hi;
        model(MULT, 32'h12345678, 32'h100, lat);
        bus.start = 1'b1; bus.op = MULT; bus.a = 32'h12345678; bus.b = 32'h100;
        @(negedge clk);
        bus.start = 1'b1; bus.op = MTHI; bus.a = 32'hDEADBEEF; bus.b = '0;
        @(negedge clk);
        bus.start = 1'b0; bus.op = NONE;
        n = 2;
        while (bus.busy === 1'b1 && n < 100) begin
            check("busy_mthi_hold_hi", bus.hi, old_hi);
            n++;
            @(negedge clk);
        end
        check("busy_mthi_cycles", 32'(n), 32'(MC + 1));
        check("busy_mthi_hi", bus.hi, exp_hi);
        check("busy_mthi_lo", bus.lo, exp_lo);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if (i == 5) begin rop = DIV; ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
